pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_next_sel.sv | 31 +++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM state encoding and next-PC select codes.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_ISSUE    = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_TRAP   = 2'd2,
        SEL_BOOT   = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch bus and downstream instruction handshake between the sequencer and its environment.
interface pc_sequencer_if;

    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;
    logic        Instr_Valid;
    logic [31:0] Instr;
    logic        Instr_Ready;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;

    modport master (
        output Mem_Req, Mem_Addr, Instr_Valid, Instr,
        input  Mem_Ack, Mem_Rdata, Instr_Ready, Branch_Taken, Branch_Target
    );

    modport slave (
        input  Mem_Req, Mem_Addr, Instr_Valid, Instr,
        output Mem_Ack, Mem_Rdata, Instr_Ready, Branch_Taken, Branch_Target
    );

endinterface

// File: rtl/pc_next_sel.sv
// Decodes a next-PC select code into the load value and write/increment strobes of the PC register.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        upd_en,
    input  pc_sel_e     sel,
    input  logic [31:0] branch_target,
    output logic [31:0] Pc_D,
    output logic        Pc_Write,
    output logic        Pc_Increment
);

    always_comb begin
        Pc_D         = 32'h0;
        Pc_Write     = 1'b0;
        Pc_Increment = 1'b0;
        if (upd_en) begin
            Pc_Write = 1'b1;
            case (sel)
                SEL_BOOT:   Pc_D = RESET_VECTOR;
                SEL_TRAP:   Pc_D = TRAP_VECTOR;
                SEL_BRANCH: Pc_D = branch_target;
                default:    Pc_Increment = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer steering an external PC register; optional trap entry when PC_SEQ_TRAP_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [31:0]           Pc_Q,
    output logic [31:0]           Pc_D,
    output logic                  Pc_Write,
    output logic                  Pc_Increment,
    input  logic                  Trap_Req,
    output logic                  Trap_Ack,
    pc_sequencer_if.master        bus
);

    seq_state_e  state, next_state;
    logic [31:0] addr_q;
    logic [31:0] instr_q;
    logic        accept;
    logic        trap_take;
    logic        upd_en;
    pc_sel_e     sel;

    assign accept = (state == ST_ISSUE) && bus.Instr_Ready;

`ifdef PC_SEQ_TRAP_EN
    logic trap_pend;

    // A trap request arriving in the accept cycle itself is held for the following accept.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            trap_pend <= 1'b0;
        end else begin
            trap_pend <= (trap_pend && !trap_take) || Trap_Req;
        end
    end

    assign trap_take = accept && trap_pend;
    assign Trap_Ack  = trap_take;
`else
    logic unused_trap_req;
    assign unused_trap_req = Trap_Req;
    assign trap_take       = 1'b0;
    assign Trap_Ack        = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= ST_BOOT;
            addr_q  <= 32'h0;
            instr_q <= 32'h0;
        end else begin
            state <= next_state;
            if (state == ST_FETCH) begin
                addr_q <= Pc_Q;
            end
            if ((state == ST_WAIT_ACK) && bus.Mem_Ack) begin
                instr_q <= bus.Mem_Rdata;
            end
        end
    end

    // BOOT is also the reset state; gating with Resetn keeps Pc_Write low while reset is held.
    always_comb begin
        next_state = state;
        upd_en     = 1'b0;
        sel        = SEL_SEQ;
        case (state)
            ST_BOOT: begin
                upd_en     = Resetn;
                sel        = SEL_BOOT;
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.Mem_Ack) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.Instr_Ready) begin
                    upd_en     = 1'b1;
                    next_state = ST_FETCH;
                    if (trap_take) begin
                        sel = SEL_TRAP;
                    end else if (bus.Branch_Taken) begin
                        sel = SEL_BRANCH;
                    end else begin
                        sel = SEL_SEQ;
                    end
                end
            end
            default: next_state = ST_BOOT;
        endcase
    end

    assign bus.Mem_Req     = (state == ST_FETCH) || (state == ST_WAIT_ACK);
    assign bus.Mem_Addr    = (state == ST_FETCH) ? Pc_Q : addr_q;
    assign bus.Instr_Valid = (state == ST_ISSUE);
    assign bus.Instr       = instr_q;

    pc_next_sel #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_next_sel (
        .upd_en        (upd_en),
        .sel           (sel),
        .branch_target (bus.Branch_Target),
        .Pc_D          (Pc_D),
        .Pc_Write      (Pc_Write),
        .Pc_Increment  (Pc_Increment)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer with a behavioural PC register; trap cases follow PC_SEQ_TRAP_EN.
module tb_pc_sequencer;

    typedef struct {
        logic [31:0] d;
        bit          inc;
        bit          ack;
    } pcw_t;

    logic        Clock;
    logic        Resetn;
    logic [31:0] Pc_Q;
    logic [31:0] Pc_D;
    logic        Pc_Write;
    logic        Pc_Increment;
    logic        Trap_Req;
    logic        Trap_Ack;

    pc_sequencer_if bus();

    pcw_t        pcw_q[$];
    logic [31:0] fetch_q[$];
    logic [31:0] instr_q[$];

    int n_cmp = 0;
    int n_err = 0;
    logic req_prev = 1'b0;

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0100),
        .TRAP_VECTOR  (32'h0000_0010)
    ) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Pc_Q         (Pc_Q),
        .Pc_D         (Pc_D),
        .Pc_Write     (Pc_Write),
        .Pc_Increment (Pc_Increment),
        .Trap_Req     (Trap_Req),
        .Trap_Ack     (Trap_Ack),
        .bus          (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural model of the external PC register.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Pc_Q <= 32'h0;
        end else if (Pc_Write) begin
            Pc_Q <= Pc_Increment ? Pc_Q + 32'h1 : Pc_D;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a PC write, a new fetch or an accepted instruction.
    always @(negedge Clock) begin
        pcw_t e;
        logic [31:0] ea;
        if (Resetn) begin
            if (Pc_Write) begin
                n_cmp++;
                if (pcw_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pc_write_unexpected: got Pc_D=%h inc=%b, no write expected", Pc_D, Pc_Increment);
                end else begin
                    e = pcw_q.pop_front();
                    if (Pc_Increment !== e.inc || (!e.inc && Pc_D !== e.d) || Trap_Ack !== e.ack) begin
                        n_err++;
                        $display("FAIL pc_write: got Pc_D=%h inc=%b ack=%b, want Pc_D=%h inc=%b ack=%b",
                                 Pc_D, Pc_Increment, Trap_Ack, e.d, e.inc, e.ack);
                    end
                end
            end else if (Trap_Ack !== 1'b0) begin
                n_cmp++;
                n_err++;
                $display("FAIL trap_ack_stray: got Trap_Ack=%b without Pc_Write, want 0", Trap_Ack);
            end
            if (bus.Mem_Req && !req_prev) begin
                n_cmp++;
                if (fetch_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fetch_unexpected: got Mem_Addr=%h, no fetch expected", bus.Mem_Addr);
                end else begin
                    ea = fetch_q.pop_front();
                    if (bus.Mem_Addr !== ea) begin
                        n_err++;
                        $display("FAIL fetch_addr: got %h, want %h", bus.Mem_Addr, ea);
                    end
                end
            end
            if (bus.Instr_Valid && bus.Instr_Ready) begin
                n_cmp++;
                if (instr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL instr_unexpected: got Instr=%h, no issue expected", bus.Instr);
                end else begin
                    ea = instr_q.pop_front();
                    if (bus.Instr !== ea) begin
                        n_err++;
                        $display("FAIL instr: got %h, want %h", bus.Instr, ea);
                    end
                end
            end
        end
        req_prev = bus.Mem_Req;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_req",   {31'h0, bus.Mem_Req},     32'h0);
        chk("rst_mem_addr",  bus.Mem_Addr,             32'h0);
        chk("rst_instr_vld", {31'h0, bus.Instr_Valid}, 32'h0);
        chk("rst_instr",     bus.Instr,                32'h0);
        chk("rst_pc_write",  {31'h0, Pc_Write},        32'h0);
        chk("rst_pc_inc",    {31'h0, Pc_Increment},    32'h0);
        chk("rst_pc_d",      Pc_D,                     32'h0);
        chk("rst_trap_ack",  {31'h0, Trap_Ack},        32'h0);
    endtask

    task automatic push_boot(input logic [31:0] rv);
        pcw_t e;
        e.d = rv; e.inc = 1'b0; e.ack = 1'b0;
        pcw_q.push_back(e);
        fetch_q.push_back(rv);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.Mem_Req && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        if (!bus.Mem_Req) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_mem_req: got Mem_Req=0 after %0d cycles, want 1", n);
        end
    endtask

    task automatic tx(input int waits, input logic [31:0] rdata, input int stall,
                      input bit br, input logic [31:0] tgt, input bit trap,
                      input logic [31:0] exp_d, input bit exp_inc, input bit exp_ack,
                      input logic [31:0] exp_next);
        pcw_t e;
        e.d = exp_d; e.inc = exp_inc; e.ack = exp_ack;
        instr_q.push_back(rdata);
        pcw_q.push_back(e);
        fetch_q.push_back(exp_next);
        wait_req();
        @(posedge Clock); #1;
        for (int i = 0; i < waits; i++) begin
            Trap_Req = trap && (i == 0);
            @(posedge Clock); #1;
        end
        Trap_Req = 1'b0;
        bus.Mem_Ack = 1'b1;
        bus.Mem_Rdata = rdata;
        @(posedge Clock); #1;
        bus.Mem_Ack = 1'b0;
        bus.Mem_Rdata = ~rdata;
        // Stray acks and branch requests while stalled must not disturb the offered instruction.
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", {31'h0, bus.Instr_Valid}, 32'h1);
            chk("stall_instr", bus.Instr, rdata);
            bus.Mem_Ack = (i == 0);
            bus.Branch_Taken = 1'b1;
            bus.Branch_Target = 32'hBAD0_0000;
            @(posedge Clock); #1;
            bus.Mem_Ack = 1'b0;
        end
        bus.Branch_Taken = br;
        bus.Branch_Target = tgt;
        bus.Instr_Ready = 1'b1;
        @(posedge Clock); #1;
        bus.Instr_Ready = 1'b0;
        bus.Branch_Taken = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] trap_d;
        logic [31:0] trap_next;
        bit          trap_ack;

        Resetn = 1'b0;
        Trap_Req = 1'b0;
        bus.Mem_Ack = 1'b0;
        bus.Mem_Rdata = 32'h0;
        bus.Instr_Ready = 1'b0;
        bus.Branch_Taken = 1'b0;
        bus.Branch_Target = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        check_reset_outputs();

        push_boot(32'h0000_0100);
        Resetn = 1'b1;

        tx(3, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0101);
        tx(0, 32'h1234_5678, 5, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0040);
        tx(1, 32'hA5A5_5A5A, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
        tx(2, 32'h0000_0001, 0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000);

`ifdef PC_SEQ_TRAP_EN
        trap_d = 32'h0000_0010; trap_ack = 1'b1; trap_next = 32'h0000_0010;
`else
        trap_d = 32'h0000_0080; trap_ack = 1'b0; trap_next = 32'h0000_0080;
`endif
        tx(2, 32'hC0DE_CAFE, 0, 1'b1, 32'h0000_0080, 1'b1, trap_d, 1'b0, trap_ack, trap_next);

        // Abort a fetch in WAIT_ACK; the late acknowledge must be ignored through BOOT and FETCH.
        wait_req();
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Resetn = 1'b0;
        #1;
        check_reset_outputs();
        bus.Mem_Ack = 1'b1;
        bus.Mem_Rdata = 32'hFEED_FACE;
        @(posedge Clock); #1;
        check_reset_outputs();
        push_boot(32'h0000_0100);
        Resetn = 1'b1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        bus.Mem_Ack = 1'b0;

        tx(0, 32'h0BAD_F00D, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0101);

        repeat (3) @(posedge Clock);
        #1;
        chk("pcw_q_drained",   pcw_q.size(),   32'h0);
        chk("fetch_q_drained", fetch_q.size(), 32'h0);
        chk("instr_q_drained", instr_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
